// File: rtl/buffer_stall_ctrl.sv
// buffer_stall_ctrl: shares one buffer_slots instance between NUM_REQ requesters.
// Round-robin arbitration in RUN. When downstream stalls, the word sent to the
// buffer is mirrored in a shadow register. HOLD keeps replaying that word into the
// buffer inputs until the overflow slot has drained.
module buffer_stall_ctrl #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ID_W     = 2,
    parameter int unsigned MAX_HOLD = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ*32-1:0]   req_data,
    output logic [NUM_REQ-1:0]      gnt,
    input  logic                    ds_ready,
    output logic [31:0]             buf_inputs,
    output logic                    buf_stall,
    input  logic                    buf_overflow,
    output logic                    out_valid,
    output logic [ID_W-1:0]         out_src,
    output logic                    hold_timeout,
    output logic                    proto_err
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned SUM_W  = ID_W + 1;

    localparam logic [SUM_W-1:0] REQ_CNT  = SUM_W'(NUM_REQ);
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0]   shadow_data_q, shadow_data_d;
    logic [ID_W-1:0]     shadow_src_q, shadow_src_d;
    logic                shadow_vld_q, shadow_vld_d;
    logic [CNT_W-1:0]    hold_cnt_q, hold_cnt_d;
    logic                first_q, first_d;
    logic                out_valid_q, out_valid_d;
    logic [ID_W-1:0]     out_src_q, out_src_d;
    logic                hold_timeout_q, hold_timeout_d;
    logic                proto_err_q, proto_err_d;

    logic [DATA_W-1:0]   data_arr [NUM_REQ];
    logic                win_vld;
    logic [ID_W-1:0]     win_idx;
    logic [SUM_W-1:0]    sum;
    logic [ID_W-1:0]     cand;
    logic [ID_W-1:0]     ptr_after_win;

    // Unpack the flat per-requester data bus
    always_comb begin
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            data_arr[k] = req_data[k*DATA_W +: DATA_W];
        end
    end

    // Round-robin search starting at rr_ptr_q
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        sum     = '0;
        cand    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr_q} + SUM_W'(k);
            if (sum >= REQ_CNT) begin
                sum = sum - REQ_CNT;
            end
            cand = ID_W'(sum);
            if (!win_vld && req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
        ptr_after_win = (win_idx == LAST_ID) ? '0 : win_idx + ID_W'(1);
    end

    // Combinational buffer drive and grant; all forced low while reset is held
    always_comb begin
        gnt        = '0;
        buf_stall  = 1'b0;
        buf_inputs = '0;
        if (reset) begin
            buf_stall = ~ds_ready;
            if (state_q == ST_RUN) begin
                if (win_vld) begin
                    gnt[win_idx] = 1'b1;
                    buf_inputs   = data_arr[win_idx];
                end
            end else begin
                buf_inputs = shadow_data_q;
            end
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        shadow_data_d  = shadow_data_q;
        shadow_src_d   = shadow_src_q;
        shadow_vld_d   = shadow_vld_q;
        hold_cnt_d     = hold_cnt_q;
        first_d        = 1'b0;
        out_valid_d    = 1'b0;
        out_src_d      = out_src_q;
        hold_timeout_d = hold_timeout_q;
        proto_err_d    = proto_err_q;

        unique case (state_q)
            ST_RUN: begin
                if (win_vld) begin
                    rr_ptr_d = ptr_after_win;
                end
                if (ds_ready) begin
                    out_valid_d = win_vld;
                    if (win_vld) begin
                        out_src_d = win_idx;
                    end
                end else begin
                    // Buffer captures this cycle's inputs into its overflow slot
                    shadow_data_d = buf_inputs;
                    shadow_src_d  = win_idx;
                    shadow_vld_d  = win_vld;
                    hold_cnt_d    = '0;
                    first_d       = 1'b1;
                    state_d       = ST_HOLD;
                end
                if (!first_q && buf_overflow) begin
                    proto_err_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (ds_ready) begin
                    // Overflow slot moves to the buffer outputs this cycle
                    out_valid_d  = shadow_vld_q;
                    if (shadow_vld_q) begin
                        out_src_d = shadow_src_q;
                    end
                    shadow_vld_d = 1'b0;
                    first_d      = 1'b1;
                    state_d      = ST_RUN;
                end else begin
                    if (hold_cnt_q != HOLD_MAX) begin
                        hold_cnt_d = hold_cnt_q + CNT_W'(1);
                    end
                    if (hold_cnt_d == HOLD_MAX) begin
                        hold_timeout_d = 1'b1;
                    end
                end
                if (!first_q && !buf_overflow) begin
                    proto_err_d = 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= ST_RUN;
            rr_ptr_q       <= '0;
            shadow_data_q  <= '0;
            shadow_src_q   <= '0;
            shadow_vld_q   <= 1'b0;
            hold_cnt_q     <= '0;
            first_q        <= 1'b1;
            out_valid_q    <= 1'b0;
            out_src_q      <= '0;
            hold_timeout_q <= 1'b0;
            proto_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            shadow_data_q  <= shadow_data_d;
            shadow_src_q   <= shadow_src_d;
            shadow_vld_q   <= shadow_vld_d;
            hold_cnt_q     <= hold_cnt_d;
            first_q        <= first_d;
            out_valid_q    <= out_valid_d;
            out_src_q      <= out_src_d;
            hold_timeout_q <= hold_timeout_d;
            proto_err_q    <= proto_err_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_src      = out_src_q;
    assign hold_timeout = hold_timeout_q;
    assign proto_err    = proto_err_q;

endmodule

// File: tb/tb_buffer_stall_ctrl.sv
// Bench for buffer_stall_ctrl: directed scenarios plus a randomized stream,
// checked against a cycle-level behavioural model and a buffer_slots model.
module tb_buffer_stall_ctrl;

    localparam int unsigned N  = 4;
    localparam int unsigned IW = 2;
    localparam int unsigned MH = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req;
    logic [N*32-1:0]   req_data;
    logic [N-1:0]      gnt;
    logic              ds_ready;
    logic [31:0]       buf_inputs;
    logic              buf_stall;
    logic              buf_overflow;
    logic              out_valid;
    logic [IW-1:0]     out_src;
    logic              hold_timeout;
    logic              proto_err;

    buffer_stall_ctrl #(.NUM_REQ(N), .ID_W(IW), .MAX_HOLD(MH)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_data     (req_data),
        .gnt          (gnt),
        .ds_ready     (ds_ready),
        .buf_inputs   (buf_inputs),
        .buf_stall    (buf_stall),
        .buf_overflow (buf_overflow),
        .out_valid    (out_valid),
        .out_src      (out_src),
        .hold_timeout (hold_timeout),
        .proto_err    (proto_err)
    );

    always #5 clk = ~clk;

    // Model of buffer_slots: main output register plus one overflow slot
    logic [31:0] bs_out;
    logic [31:0] bs_ovf_data;
    logic        bs_ovf;
    always @(posedge clk) begin
        if (!reset) begin
            bs_out      <= '0;
            bs_ovf_data <= '0;
            bs_ovf      <= 1'b0;
        end else if (buf_stall) begin
            bs_ovf_data <= buf_inputs;
            bs_ovf      <= 1'b1;
        end else if (bs_ovf) begin
            bs_out <= bs_ovf_data;
            bs_ovf <= 1'b0;
        end else begin
            bs_out <= buf_inputs;
        end
    end
    assign buf_overflow = bs_ovf;

    typedef struct {
        int          src;
        logic [31:0] data;
    } word_t;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] tb_data [N];

    // Behavioural reference state
    bit          m_hold;
    int          m_ptr;
    bit          m_pend;
    logic [31:0] m_sh_data;
    int          m_hold_len;
    bit          m_timeout;
    bit          exp_valid;
    word_t       exp_q [$];
    int          last_w;

    // Stream bookkeeping
    bit          in_stream;
    int          delivered;
    bit          seen [64];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check combinational outputs, advance model, check registered outputs
    task automatic step(input logic [N-1:0] r, input logic ds, input logic rst);
        int          w;
        int          idx;
        logic [N-1:0] e_gnt;
        logic [31:0] e_in;
        word_t       f;
        @(negedge clk);
        req      = r;
        ds_ready = ds;
        reset    = rst;
        for (int i = 0; i < int'(N); i++) req_data[32*i +: 32] = tb_data[i];
        #1;
        w = -1;
        if (rst && !m_hold) begin
            for (int k = 0; k < int'(N); k++) begin
                idx = (m_ptr + k) % int'(N);
                if (w < 0 && r[idx]) w = idx;
            end
        end
        e_gnt = (w >= 0) ? N'(1 << w) : '0;
        if (!rst)        e_in = '0;
        else if (m_hold) e_in = m_sh_data;
        else             e_in = (w >= 0) ? tb_data[w] : '0;
        check("gnt", 32'(gnt), 32'(e_gnt));
        check("buf_stall", 32'(buf_stall), 32'(rst & ~ds));
        check("buf_inputs", buf_inputs, e_in);
        last_w = w;
        @(posedge clk);
        if (!rst) begin
            m_hold = 0; m_ptr = 0; m_pend = 0; m_sh_data = '0;
            m_hold_len = 0; m_timeout = 0; exp_valid = 0;
            exp_q.delete();
        end else if (!m_hold) begin
            if (w >= 0) begin
                exp_q.push_back('{src: w, data: tb_data[w]});
                m_ptr = (w + 1) % int'(N);
            end
            if (ds) begin
                exp_valid = (w >= 0);
            end else begin
                m_hold = 1; m_hold_len = 0; m_pend = (w >= 0);
                m_sh_data = (w >= 0) ? tb_data[w] : '0;
                exp_valid = 0;
            end
        end else begin
            if (ds) begin
                exp_valid = m_pend; m_pend = 0; m_hold = 0;
            end else begin
                m_hold_len++;
                if (m_hold_len >= int'(MH)) m_timeout = 1;
                exp_valid = 0;
            end
        end
        #1;
        check("out_valid", 32'(out_valid), 32'(exp_valid));
        if (exp_valid) begin
            check("word_available", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                f = exp_q.pop_front();
                check("out_src", 32'(out_src), 32'(f.src));
                check("out_data", bs_out, f.data);
                if (in_stream) begin
                    check("stream_dup", 32'(seen[bs_out[5:0]]), 32'd0);
                    seen[bs_out[5:0]] = 1;
                    delivered++;
                end
            end
        end
        check("hold_timeout", 32'(hold_timeout), 32'(m_timeout));
        check("proto_err", 32'(proto_err), 32'd0);
    endtask

    initial begin
        int c0;
        int c1;
        int budget;
        logic [N-1:0] r;
        req = '0; ds_ready = 1'b1; reset = 1'b0; req_data = '0;
        in_stream = 0; delivered = 0; last_w = -1;
        for (int i = 0; i < int'(N); i++) tb_data[i] = 32'hA000_0000 | 32'(i);

        // Reset
        step('0, 1'b1, 1'b0);
        step('0, 1'b1, 1'b0);
        check("reset_out_src", 32'(out_src), 32'd0);

        // All requesters active, no stalls: grants rotate 0,1,2,3,...
        for (int c = 0; c < 8; c++) begin
            step('1, 1'b1, 1'b1);
            check("rr_order", 32'(last_w), 32'(c % 4));
        end
        step('0, 1'b1, 1'b1);

        // Request 2 arrives as downstream stalls for five cycles
        tb_data[2] = 32'hCAFE_0002;
        step(4'b0100, 1'b0, 1'b1);
        for (int c = 0; c < 4; c++) step(4'b0100, 1'b0, 1'b1);
        step(4'b0100, 1'b1, 1'b1);
        check("cafe_valid", 32'(out_valid), 32'd1);
        check("cafe_data", bs_out, 32'hCAFE_0002);
        step('0, 1'b1, 1'b1);
        check("cafe_once", 32'(out_valid), 32'd0);

        // Stall without any request: nothing delivered after release
        step('0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b1);
        step('0, 1'b1, 1'b1);
        step('0, 1'b1, 1'b1);

        // Long stall past MAX_HOLD: timeout sticks after returning to RUN
        for (int c = 0; c < int'(MH) + 2; c++) step('0, 1'b0, 1'b1);
        step('0, 1'b1, 1'b1);
        step(4'b0010, 1'b1, 1'b1);
        check("timeout_sticky", 32'(hold_timeout), 32'd1);

        // Reset during HOLD with a pending shadow word
        step('0, 1'b1, 1'b0);
        step(4'b0010, 1'b1, 1'b1);
        step(4'b0001, 1'b0, 1'b1);
        step('0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b0);
        step('0, 1'b1, 1'b1);
        step(4'b0011, 1'b1, 1'b1);
        check("post_reset_ptr", 32'(last_w), 32'd0);
        step('0, 1'b1, 1'b1);

        // Randomized stream of 0x1..0x20 from requesters 0 and 1
        in_stream = 1; delivered = 0;
        for (int i = 0; i < 64; i++) seen[i] = 0;
        c0 = 0; c1 = 0; budget = 0;
        while (delivered < 32 && budget < 2000) begin
            tb_data[0] = 32'(c0 + 1);
            tb_data[1] = 32'(c1 + 17);
            r = '0;
            r[0] = (c0 < 16) && ($urandom_range(3) != 0);
            r[1] = (c1 < 16) && ($urandom_range(3) != 0);
            step(r, 1'($urandom_range(1)), 1'b1);
            if (last_w == 0) c0++;
            if (last_w == 1) c1++;
            budget++;
        end
        in_stream = 0;
        check("stream_delivered", 32'(delivered), 32'd32);
        check("stream_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
